// File: rtl/rtc_alrm_pkg.sv
// Shared types for the RTC alarm scheduler: FSM state encoding and the per-slot record.
// Slot fields are sized for the widest supported counter; bits above CNT_WIDTH stay zero.
package rtc_alrm_pkg;

    localparam int CNT_W_MAX = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic                 en;
        logic [CNT_W_MAX-1:0] cmp;
        logic [CNT_W_MAX-1:0] period;
    } slot_t;

endpackage

// File: rtl/rtc_alrm_cmp.sv
// Shared alarm comparator: equality of the snapshot against one slot, plus the reloaded compare value.
// RTC_ALRM_PERIODIC_EN adds cmp+period reload on a match when period is non-zero.
module rtc_alrm_cmp
    import rtc_alrm_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic [CNT_WIDTH-1:0] snap,
    input  slot_t                slot,
    output logic                 match,
    output logic [CNT_W_MAX-1:0] next_cmp
);

    logic [CNT_W_MAX-1:0] snap_ext;

    assign snap_ext = CNT_W_MAX'(snap);
    assign match    = slot.en && (snap_ext == slot.cmp);

`ifdef RTC_ALRM_PERIODIC_EN
    logic [CNT_W_MAX-1:0] cmp_mask;

    // Keeps the reload wrapping modulo 2^CNT_WIDTH
    assign cmp_mask = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - CNT_WIDTH);
    assign next_cmp = (slot.period != '0) ? ((slot.cmp + slot.period) & cmp_mask) : slot.cmp;
`else
    logic unused_period;

    assign unused_period = ^slot.period;
    assign next_cmp      = slot.cmp;
`endif

endmodule

// File: rtl/rtc_alrm_sched.sv
// RTC alarm scheduler: on each tick, scans all slots one per cycle through a single comparator.
// Optional periodic reload is enabled with the RTC_ALRM_PERIODIC_EN macro.
//
// state | meaning
// IDLE  | waiting for tick_i or a queued tick; configuration accepted here
// SCAN  | comparing snap against slot[ptr], one slot per cycle
module rtc_alrm_sched
    import rtc_alrm_pkg::*;
#(
    parameter int SLOT_NUM  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CNT_WIDTH-1:0]        cnt_i,
    input  logic                        tick_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [$clog2(SLOT_NUM)-1:0] cfg_slot_i,
    input  logic                        cfg_en_i,
    input  logic [CNT_WIDTH-1:0]        cfg_cmp_i,
    input  logic [CNT_WIDTH-1:0]        cfg_period_i,
    input  logic                        ack_valid_i,
    input  logic [$clog2(SLOT_NUM)-1:0] ack_slot_i,
    output logic [SLOT_NUM-1:0]         pend_o,
    output logic                        irq_o,
    output logic                        busy_o,
    output logic                        ovr_o
);

    localparam int PTR_W = $clog2(SLOT_NUM);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_WIDTH-1:0] snap_q;
    logic                 tick_pend_q;
    logic                 ovr_q;
    logic                 irq_q;
    logic [SLOT_NUM-1:0]  pend_q, pend_d;
    slot_t                slots [SLOT_NUM];

    logic                 start, scanning, last_slot;
    logic                 cfg_fire, cfg_in_range, ack_in_range;
    logic                 match;
    logic [CNT_W_MAX-1:0] next_cmp;

    assign last_slot    = (ptr_q == PTR_W'(SLOT_NUM - 1));
    assign cfg_in_range = (32'(cfg_slot_i) < SLOT_NUM);
    assign ack_in_range = (32'(ack_slot_i) < SLOT_NUM);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick_i || tick_pend_q) state_d = ST_SCAN;
            ST_SCAN: if (last_slot)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == ST_SCAN);
        scanning    = (state_q == ST_SCAN);
        start       = (state_q == ST_IDLE) && (tick_i || tick_pend_q);
        cfg_ready_o = (state_q == ST_IDLE) && !tick_pend_q && !tick_i && !rst_i;
        cfg_fire    = cfg_ready_o && cfg_valid_i;
    end

    rtc_alrm_cmp #(.CNT_WIDTH(CNT_WIDTH)) u_cmp (
        .snap     (snap_q),
        .slot     (slots[ptr_q]),
        .match    (match),
        .next_cmp (next_cmp)
    );

    // A scan hit takes priority over an ack or config clear to the same slot
    always_comb begin
        pend_d = pend_q;
        if (cfg_fire && cfg_in_range)  pend_d[cfg_slot_i] = 1'b0;
        if (ack_valid_i && ack_in_range) pend_d[ack_slot_i] = 1'b0;
        if (scanning && match)         pend_d[ptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            snap_q      <= '0;
            tick_pend_q <= 1'b0;
            ovr_q       <= 1'b0;
            irq_q       <= 1'b0;
            pend_q      <= '0;
            for (int i = 0; i < SLOT_NUM; i++) slots[i] <= '0;
        end else begin
            irq_q  <= |pend_q;
            pend_q <= pend_d;
            if (start) begin
                snap_q      <= cnt_i;
                ptr_q       <= '0;
                tick_pend_q <= 1'b0;
            end else if (scanning) begin
                ptr_q <= last_slot ? '0 : ptr_q + 1'b1;
                if (tick_i) begin
                    if (tick_pend_q) ovr_q       <= 1'b1;
                    else             tick_pend_q <= 1'b1;
                end
            end
            if (cfg_fire && cfg_in_range) begin
                slots[cfg_slot_i].en  <= cfg_en_i;
                slots[cfg_slot_i].cmp <= CNT_W_MAX'(cfg_cmp_i);
`ifdef RTC_ALRM_PERIODIC_EN
                slots[cfg_slot_i].period <= CNT_W_MAX'(cfg_period_i);
`endif
            end
            if (scanning && match) slots[ptr_q].cmp <= next_cmp;
        end
    end

`ifndef RTC_ALRM_PERIODIC_EN
    logic unused_cfg_period;

    assign unused_cfg_period = ^cfg_period_i;
`endif

    assign pend_o = pend_q;
    assign irq_o  = irq_q;
    assign ovr_o  = ovr_q;

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Directed bench for rtc_alrm_sched: vector table of single-scan cases plus multi-cycle sequences.
// Expectations for periodic reload follow RTC_ALRM_PERIODIC_EN as seen by this compile.
module tb_rtc_alrm_sched;

    localparam int SLOT_NUM  = 4;
    localparam int CNT_WIDTH = 32;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [CNT_WIDTH-1:0] cnt_i;
    logic                 tick_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [1:0]           cfg_slot_i;
    logic                 cfg_en_i;
    logic [CNT_WIDTH-1:0] cfg_cmp_i;
    logic [CNT_WIDTH-1:0] cfg_period_i;
    logic                 ack_valid_i;
    logic [1:0]           ack_slot_i;
    logic [SLOT_NUM-1:0]  pend_o;
    logic                 irq_o;
    logic                 busy_o;
    logic                 ovr_o;

    int checks = 0;
    int errors = 0;

    rtc_alrm_sched #(.SLOT_NUM(SLOT_NUM), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cnt_i        (cnt_i),
        .tick_i       (tick_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_slot_i   (cfg_slot_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_cmp_i    (cfg_cmp_i),
        .cfg_period_i (cfg_period_i),
        .ack_valid_i  (ack_valid_i),
        .ack_slot_i   (ack_slot_i),
        .pend_o       (pend_o),
        .irq_o        (irq_o),
        .busy_o       (busy_o),
        .ovr_o        (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]       en;
        logic [3:0][31:0] cmp;
        logic [31:0]      cnt;
        logic [3:0]       exp_pend;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_one(input logic [1:0] slot, input logic en, input logic [31:0] cmp,
                           input logic [31:0] period);
        int n = 0;
        cfg_valid_i  = 1'b1;
        cfg_slot_i   = slot;
        cfg_en_i     = en;
        cfg_cmp_i    = cmp;
        cfg_period_i = period;
        while (!cfg_ready_o && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL cfg_ready_timeout: got cfg_ready_o=0 for %0d cycles expected 1", n);
        end
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic cfg_all(input logic [3:0] en, input logic [3:0][31:0] cmp, input logic [31:0] period);
        for (int i = 0; i < 4; i++) cfg_one(2'(i), en[i], cmp[i], period);
    endtask

    task automatic tick(input logic [31:0] c);
        cnt_i  = c;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    // Called right after the tick edge: finishes the scan, then checks pend and the delayed irq
    task automatic scan_check(input string name, input logic [3:0] exp_pend);
        repeat (SLOT_NUM) step();
        check({name, "_pend"}, 64'(pend_o), 64'(exp_pend));
        check({name, "_busy"}, 64'(busy_o), 64'd0);
        step();
        check({name, "_irq"}, 64'(irq_o), 64'(|exp_pend));
    endtask

    task automatic ack(input logic [1:0] slot);
        ack_valid_i = 1'b1;
        ack_slot_i  = slot;
        step();
        ack_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{4'b0010, {32'h0, 32'h0, 32'h10, 32'h0}, 32'h10, 4'b0010};
        vecs[1] = '{4'b1111, {32'h55, 32'h55, 32'h55, 32'h55}, 32'h55, 4'b1111};
        vecs[2] = '{4'b0101, {32'h55, 32'h55, 32'h55, 32'h55}, 32'h55, 4'b0101};
        vecs[3] = '{4'b1111, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h3, 4'b0100};
        vecs[4] = '{4'b1111, {32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF}, 32'hFFFFFFFF, 4'b1001};
        vecs[5] = '{4'b1111, {32'h10, 32'h9, 32'h8, 32'h7}, 32'h20, 4'b0000};

        rst_i = 1'b1; cnt_i = '0; tick_i = 1'b0;
        cfg_valid_i = 1'b0; cfg_slot_i = '0; cfg_en_i = 1'b0; cfg_cmp_i = '0; cfg_period_i = '0;
        ack_valid_i = 1'b0; ack_slot_i = '0;
        repeat (3) step();
        check("rst_cfg_ready", 64'(cfg_ready_o), 64'd0);
        check("rst_pend", 64'(pend_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ovr", 64'(ovr_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("idle_cfg_ready", 64'(cfg_ready_o), 64'd1);

        // Single match on slot 1: exact latency of pend and irq
        cfg_all(4'b0010, {32'h0, 32'h0, 32'h10, 32'h0}, 32'h0);
        tick(32'h10);
        check("lat_busy_e0", 64'(busy_o), 64'd1);
        check("lat_pend_e0", 64'(pend_o), 64'd0);
        step();
        check("lat_pend_e1", 64'(pend_o), 64'd0);
        step();
        check("lat_pend_e2", 64'(pend_o), 64'b0010);
        check("lat_irq_e2", 64'(irq_o), 64'd0);
        step();
        check("lat_irq_e3", 64'(irq_o), 64'd1);
        check("lat_busy_e3", 64'(busy_o), 64'd1);
        step();
        check("lat_busy_e4", 64'(busy_o), 64'd0);

        // Ack and re-match collide on slot 1: set wins
        tick(32'h10);
        step();
        ack_valid_i = 1'b1;
        ack_slot_i  = 2'd1;
        step();
        ack_valid_i = 1'b0;
        check("ack_vs_set", 64'(pend_o), 64'b0010);
        repeat (2) step();
        check("ack_vs_set_busy", 64'(busy_o), 64'd0);
        ack(2'd1);
        check("ack_clear", 64'(pend_o), 64'd0);
        step();
        check("ack_irq_clear", 64'(irq_o), 64'd0);

        for (int i = 0; i < 6; i++) begin
            cfg_all(vecs[i].en, vecs[i].cmp, 32'h0);
            check($sformatf("vec%0d_cfg_clear", i), 64'(pend_o), 64'd0);
            tick(vecs[i].cnt);
            scan_check($sformatf("vec%0d", i), vecs[i].exp_pend);
        end

        // Three back-to-back ticks: second queued, third overruns
        cfg_all(4'b0100, {32'h0, 32'h77, 32'h0, 32'h0}, 32'h0);
        cnt_i  = 32'h0;
        tick_i = 1'b1;
        repeat (3) step();
        tick_i = 1'b0;
        check("ovr_set", 64'(ovr_o), 64'd1);
        check("ovr_busy", 64'(busy_o), 64'd1);
        cnt_i = 32'h77;
        repeat (2) step();
        check("queued_idle_busy", 64'(busy_o), 64'd0);
        check("queued_idle_ready", 64'(cfg_ready_o), 64'd0);
        check("queued_first_pend", 64'(pend_o), 64'd0);
        step();
        check("queued_scan_busy", 64'(busy_o), 64'd1);
        repeat (4) step();
        check("queued_scan_pend", 64'(pend_o), 64'b0100);
        check("ovr_sticky", 64'(ovr_o), 64'd1);

        // Configuration held off by a scan and a queued tick
        cfg_all(4'b0001, {32'h0, 32'h0, 32'h0, 32'h30}, 32'h0);
        tick(32'h0);
        cfg_valid_i = 1'b1; cfg_slot_i = 2'd3; cfg_en_i = 1'b1; cfg_cmp_i = 32'h31; cfg_period_i = '0;
        cnt_i  = 32'h30;
        tick_i = 1'b1;
        check("cfg_ready_scan_tick", 64'(cfg_ready_o), 64'd0);
        step();
        tick_i = 1'b0;
        check("cfg_ready_scan", 64'(cfg_ready_o), 64'd0);
        n = 0;
        while (!cfg_ready_o && n < 40) begin
            step();
            n++;
        end
        check("cfg_wait_cycles", 64'(n), 64'd8);
        step();
        cfg_valid_i = 1'b0;
        check("cfg_no_lost_tick", 64'(pend_o), 64'b0001);
        tick(32'h31);
        scan_check("cfg_new_slot", 4'b1001);

        // Reload across the counter wrap
        cfg_all(4'b0001, {32'h0, 32'h0, 32'h0, 32'hFFFFFFF0}, 32'h20);
        tick(32'hFFFFFFF0);
        scan_check("wrap_first", 4'b0001);
        ack(2'd0);
        tick(32'h10);
`ifdef RTC_ALRM_PERIODIC_EN
        scan_check("wrap_reload", 4'b0001);
`else
        scan_check("wrap_reload", 4'b0000);
`endif
        ack(2'd0);
        tick(32'hFFFFFFF0);
`ifdef RTC_ALRM_PERIODIC_EN
        scan_check("wrap_old_cmp", 4'b0000);
`else
        scan_check("wrap_old_cmp", 4'b0001);
`endif

        // Reset in the middle of a scan
        cfg_all(4'b1000, {32'h40, 32'h0, 32'h0, 32'h0}, 32'h0);
        tick(32'h40);
        step();
        rst_i = 1'b1;
        #1;
        check("midrst_cfg_ready", 64'(cfg_ready_o), 64'd0);
        step();
        check("midrst_pend", 64'(pend_o), 64'd0);
        check("midrst_irq", 64'(irq_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ovr", 64'(ovr_o), 64'd0);
        rst_i = 1'b0;
        step();
        tick(32'h40);
        scan_check("post_rst_cfg_wiped", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
